// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble unpacker and its future packer twin:
// default widths, the two-state FSM encoding and the index-width helper.
package nibble_pkg;

   // Default word and piece widths used by both sides of the packing scheme.
   localparam int WORD_W_DEF  = 8;
   localparam int PIECE_W_DEF = 4;

   // IDLE: nothing held.  EMIT: a word is held and its pieces are offered.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } fsm_state_e;

   // Width of a piece index; never narrower than one bit so that a
   // single-piece configuration still has a legal index port.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nibble_unpacker_if.sv
// Bundle of the word-side and piece-side handshakes of the nibble unpacker.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both high.  A source holds valid and its
// payload stable until the transfer; a sink may raise or drop ready freely.
// The unpacker's word_ready is the only signal that combinationally follows
// an input (piece_ready), so the last piece and the next word can move in
// the same cycle.
interface nibble_unpacker_if
   import nibble_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int PIECE_W = PIECE_W_DEF
);

   localparam int NUM_PIECES = WORD_W / PIECE_W;
   localparam int IDX_W      = idx_width(NUM_PIECES);

   // Word side: producer -> unpacker.
   logic               word_valid;
   logic               word_ready;
   logic [WORD_W-1:0]  word;

   // Piece side: unpacker -> downstream lane.
   logic               piece_valid;
   logic               piece_ready;
   logic [PIECE_W-1:0] piece;
   logic [IDX_W-1:0]   piece_idx;
   logic               piece_last;

   // Status.
   logic               busy;

   // Environment view: drives words in and consumes pieces.
   modport master (
      output word_valid, word, piece_ready,
      input  word_ready, piece_valid, piece, piece_idx, piece_last, busy
   );

   // Unpacker view.
   modport slave (
      input  word_valid, word, piece_ready,
      output word_ready, piece_valid, piece, piece_idx, piece_last, busy
   );

endinterface

// File: rtl/nibble_unpacker.sv
// Nibble unpacker: takes one WORD_W-bit word and emits it as
// WORD_W/PIECE_W pieces, one per piece handshake.  Piece order follows the
// {upper, lower} concatenation packing when MSB_FIRST is set.  The word
// register, piece index and two-state FSM all live here; every output is a
// flop except o_WORD_READY, which looks ahead at the last-piece transfer so
// consecutive words stream without a bubble.
module nibble_unpacker
   import nibble_pkg::*;
#(
   parameter int WORD_W     = WORD_W_DEF,
   parameter int PIECE_W    = PIECE_W_DEF,
   parameter bit MSB_FIRST  = 1'b1,
   localparam int NUM_PIECES = WORD_W / PIECE_W,
   localparam int IDX_W      = idx_width(NUM_PIECES)
) (
   input  logic               i_CLOCK,
   input  logic               i_RESET_N,
   input  logic               i_WORD_VALID,
   output logic               o_WORD_READY,
   input  logic [WORD_W-1:0]  i_WORD,
   output logic               o_PIECE_VALID,
   input  logic               i_PIECE_READY,
   output logic [PIECE_W-1:0] o_PIECE,
   output logic [IDX_W-1:0]   o_PIECE_IDX,
   output logic               o_PIECE_LAST,
   output logic               o_BUSY
);

   // A word must split into a whole, non-zero number of pieces.
   if (PIECE_W < 1 || WORD_W < PIECE_W || (WORD_W % PIECE_W) != 0) begin : g_param_check
      $fatal(1, "nibble_unpacker: WORD_W must be a non-zero multiple of PIECE_W");
   end

   // FSM encodings, kept as plain vectors so the state flop is a simple reg.
   localparam logic [0:0]       ST_IDLE  = IDLE;
   localparam logic [0:0]       ST_EMIT  = EMIT;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIECES - 1);

   // Registered state.
   logic [0:0]         state_q;
   logic [WORD_W-1:0]  word_q;
   logic [IDX_W-1:0]   idx_q;
   logic [PIECE_W-1:0] piece_q;
   logic               last_q;

   // Next-state values.
   logic [0:0]         state_d;
   logic [WORD_W-1:0]  word_d;
   logic [IDX_W-1:0]   idx_d;
   logic [PIECE_W-1:0] piece_d;
   logic               last_d;

   // Handshake events.
   logic               busy;
   logic               piece_xfer;
   logic               word_ready;
   logic               word_accept;

   assign busy        = (state_q == ST_EMIT);
   assign piece_xfer  = busy & i_PIECE_READY;

   // Accept a word when empty, or when the final piece leaves this cycle.
   // Held low during reset so no word is taken on a reset edge.
   assign word_ready  = i_RESET_N & (~busy | (piece_xfer & last_q));
   assign word_accept = i_WORD_VALID & word_ready;

   // FSM, word register and index counter next-state logic.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (word_accept) begin
               state_d = ST_EMIT;
               word_d  = i_WORD;
               idx_d   = '0;
            end
         end
         ST_EMIT: begin
            if (piece_xfer) begin
               if (idx_q == LAST_IDX) begin
                  // Last piece gone: reload straight away if a word is
                  // waiting, otherwise drop back to idle.
                  idx_d = '0;
                  if (word_accept) begin
                     word_d = i_WORD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Select the piece that will be on the output after this edge, so the
   // output register is loaded with its final value and stays put under
   // backpressure (word_d and idx_d do not move without a transfer).
   always_comb begin
      piece_d = '0;
      for (int p = 0; p < NUM_PIECES; p++) begin
         if (idx_d == IDX_W'(p)) begin
            if (MSB_FIRST) begin
               piece_d = word_d[WORD_W-1-p*PIECE_W -: PIECE_W];
            end else begin
               piece_d = word_d[p*PIECE_W +: PIECE_W];
            end
         end
      end
   end

   // Last flag follows the index of the piece about to be presented.
   always_comb begin
      last_d = (state_d == ST_EMIT) && (idx_d == LAST_IDX);
   end

   // State, word, index and output registers with synchronous reset.
   always_ff @(posedge i_CLOCK) begin
      if (!i_RESET_N) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         piece_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         piece_q <= piece_d;
         last_q  <= last_d;
      end
   end

   assign o_WORD_READY  = word_ready;
   assign o_PIECE_VALID = busy;
   assign o_PIECE       = piece_q;
   assign o_PIECE_IDX   = idx_q;
   assign o_PIECE_LAST  = last_q;
   assign o_BUSY        = busy;

endmodule

// File: tb/tb_nibble_unpacker.sv
// Bench for nibble_unpacker: three instances (default, LSB-first, 16-bit
// word) share one clock and reset; a selector routes stimulus to one of
// them and its outputs to a common observation bundle.  Expected pieces
// are queued when a word is driven and checked as pieces transfer.
module tb_nibble_unpacker;
   import nibble_pkg::*;

   // Clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int busy_cycles = 0;

   // Stimulus and routing
   int          sel;
   logic        drv_wvalid;
   logic        drv_pready;
   logic [15:0] drv_word;

   // Scoreboard: {piece[3:0], idx[1:0], last}
   logic [6:0]  exp_q[$];

   nibble_unpacker_if #(.WORD_W(8),  .PIECE_W(4)) a_if ();
   nibble_unpacker_if #(.WORD_W(8),  .PIECE_W(4)) l_if ();
   nibble_unpacker_if #(.WORD_W(16), .PIECE_W(4)) w_if ();

   assign a_if.word_valid  = drv_wvalid & (sel == 0);
   assign a_if.word        = drv_word[7:0];
   assign a_if.piece_ready = drv_pready & (sel == 0);
   assign l_if.word_valid  = drv_wvalid & (sel == 1);
   assign l_if.word        = drv_word[7:0];
   assign l_if.piece_ready = drv_pready & (sel == 1);
   assign w_if.word_valid  = drv_wvalid & (sel == 2);
   assign w_if.word        = drv_word;
   assign w_if.piece_ready = drv_pready & (sel == 2);

   nibble_unpacker #(.WORD_W(8), .PIECE_W(4), .MSB_FIRST(1'b1)) dut_a (
      .i_CLOCK(clk), .i_RESET_N(rst_n),
      .i_WORD_VALID(a_if.word_valid), .o_WORD_READY(a_if.word_ready), .i_WORD(a_if.word),
      .o_PIECE_VALID(a_if.piece_valid), .i_PIECE_READY(a_if.piece_ready),
      .o_PIECE(a_if.piece), .o_PIECE_IDX(a_if.piece_idx), .o_PIECE_LAST(a_if.piece_last),
      .o_BUSY(a_if.busy)
   );

   nibble_unpacker #(.WORD_W(8), .PIECE_W(4), .MSB_FIRST(1'b0)) dut_l (
      .i_CLOCK(clk), .i_RESET_N(rst_n),
      .i_WORD_VALID(l_if.word_valid), .o_WORD_READY(l_if.word_ready), .i_WORD(l_if.word),
      .o_PIECE_VALID(l_if.piece_valid), .i_PIECE_READY(l_if.piece_ready),
      .o_PIECE(l_if.piece), .o_PIECE_IDX(l_if.piece_idx), .o_PIECE_LAST(l_if.piece_last),
      .o_BUSY(l_if.busy)
   );

   nibble_unpacker #(.WORD_W(16), .PIECE_W(4), .MSB_FIRST(1'b1)) dut_w (
      .i_CLOCK(clk), .i_RESET_N(rst_n),
      .i_WORD_VALID(w_if.word_valid), .o_WORD_READY(w_if.word_ready), .i_WORD(w_if.word),
      .o_PIECE_VALID(w_if.piece_valid), .i_PIECE_READY(w_if.piece_ready),
      .o_PIECE(w_if.piece), .o_PIECE_IDX(w_if.piece_idx), .o_PIECE_LAST(w_if.piece_last),
      .o_BUSY(w_if.busy)
   );

   // Observation bundle for the selected instance
   logic       obs_valid, obs_wready, obs_last, obs_busy;
   logic [3:0] obs_piece;
   logic [1:0] obs_idx;

   always_comb begin
      obs_valid  = a_if.piece_valid;
      obs_wready = a_if.word_ready;
      obs_last   = a_if.piece_last;
      obs_busy   = a_if.busy;
      obs_piece  = a_if.piece;
      obs_idx    = {1'b0, a_if.piece_idx};
      case (sel)
         1: begin
            obs_valid  = l_if.piece_valid;
            obs_wready = l_if.word_ready;
            obs_last   = l_if.piece_last;
            obs_busy   = l_if.busy;
            obs_piece  = l_if.piece;
            obs_idx    = {1'b0, l_if.piece_idx};
         end
         2: begin
            obs_valid  = w_if.piece_valid;
            obs_wready = w_if.word_ready;
            obs_last   = w_if.piece_last;
            obs_busy   = w_if.busy;
            obs_piece  = w_if.piece;
            obs_idx    = w_if.piece_idx;
         end
         default: ;
      endcase
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue the pieces a word should produce.
   task automatic push_word(input logic [15:0] w, input int n, input bit msb);
      logic [15:0] sh;
      for (int k = 0; k < n; k++) begin
         sh = msb ? (w >> (4 * (n - 1 - k))) : (w >> (4 * k));
         exp_q.push_back({sh[3:0], 2'(k), (k == n - 1)});
      end
   endtask

   // Consume queued pieces with the current piece_ready setting.
   task automatic consume(input string name, input int budget);
      int n = 0;
      logic [6:0] e;
      while (exp_q.size() > 0 && n < budget) begin
         if (obs_busy) busy_cycles++;
         if (obs_valid && drv_pready) begin
            e = exp_q.pop_front();
            checks++;
            if ({obs_piece, obs_idx, obs_last} !== e) begin
               errors++;
               $display("FAIL %s: piece/idx/last got %h/%0d/%0d expected %h/%0d/%0d",
                        name, obs_piece, obs_idx, obs_last, e[6:3], e[2:1], e[0]);
            end
         end
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s timeout: %0d pieces outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      sel = 0; drv_wvalid = 1'b0; drv_pready = 1'b0; drv_word = '0;
      rst_n = 1'b0;
      tick(); tick();
      checks++;
      if ({obs_valid, obs_piece, obs_idx, obs_last, obs_busy} !== 9'd0) begin
         errors++;
         $display("FAIL reset outputs: got v%0d p%h i%0d l%0d b%0d expected all 0",
                  obs_valid, obs_piece, obs_idx, obs_last, obs_busy);
      end
      checks++;
      if (obs_wready !== 1'b0) begin
         errors++;
         $display("FAIL reset word_ready: got %0d expected 0", obs_wready);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs_wready !== 1'b1) begin
         errors++;
         $display("FAIL idle word_ready: got %0d expected 1", obs_wready);
      end
   endtask

   task automatic test_single();
      sel = 0; drv_word = 16'h007C; drv_wvalid = 1'b1; drv_pready = 1'b1;
      push_word(16'h007C, 2, 1'b1);
      tick();
      drv_wvalid = 1'b0;
      busy_cycles = 0;
      consume("single", 6);
      checks++;
      if (obs_busy !== 1'b0 || busy_cycles != 2) begin
         errors++;
         $display("FAIL single busy: busy_now %0d cycles %0d expected 0 and 2", obs_busy, busy_cycles);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] e;
      sel = 0; drv_word = 16'h007C; drv_wvalid = 1'b1; drv_pready = 1'b1;
      push_word(16'h007C, 2, 1'b1);
      push_word(16'h00E2, 2, 1'b1);
      tick();
      drv_word = 16'h00E2;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) drv_wvalid = 1'b0;
         #1;
         checks++;
         if (obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b valid cycle %0d: got %0d expected 1", c, obs_valid);
         end
         checks++;
         if (obs_wready !== (c == 1 || c == 3)) begin
            errors++;
            $display("FAIL b2b word_ready cycle %0d: got %0d expected %0d", c, obs_wready, (c == 1 || c == 3));
         end
         e = exp_q.pop_front();
         checks++;
         if ({obs_piece, obs_idx, obs_last} !== e) begin
            errors++;
            $display("FAIL b2b piece cycle %0d: got %h/%0d/%0d expected %h/%0d/%0d",
                     c, obs_piece, obs_idx, obs_last, e[6:3], e[2:1], e[0]);
         end
         tick();
      end
      checks++;
      if (obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b drained: valid %0d expected 0", obs_valid);
      end
   endtask

   task automatic test_backpressure();
      sel = 0; drv_word = 16'h007C; drv_wvalid = 1'b1; drv_pready = 1'b0;
      tick();
      drv_word = 16'h0099;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if ({obs_valid, obs_piece, obs_idx, obs_last, obs_wready} !== {1'b1, 4'h7, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall cycle %0d: got v%0d p%h i%0d l%0d wr%0d expected v1 p7 i0 l0 wr0",
                     c, obs_valid, obs_piece, obs_idx, obs_last, obs_wready);
         end
         tick();
      end
      drv_wvalid = 1'b0; drv_pready = 1'b1;
      push_word(16'h007C, 2, 1'b1);
      consume("stall release", 6);
      checks++;
      if (obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall no overwrite: valid %0d piece %h expected valid 0", obs_valid, obs_piece);
      end
   endtask

   task automatic test_lsb_first();
      sel = 1; drv_word = 16'h007C; drv_wvalid = 1'b1; drv_pready = 1'b1;
      push_word(16'h007C, 2, 1'b0);
      tick();
      drv_wvalid = 1'b0;
      consume("lsb first", 6);
   endtask

   task automatic test_wide_word();
      sel = 2; drv_word = 16'hA5C3; drv_wvalid = 1'b1; drv_pready = 1'b1;
      push_word(16'hA5C3, 4, 1'b1);
      tick();
      drv_wvalid = 1'b0;
      consume("wide word", 10);
   endtask

   task automatic test_reset_mid_word();
      sel = 0; drv_word = 16'h007C; drv_wvalid = 1'b1; drv_pready = 1'b1;
      tick();
      drv_wvalid = 1'b0;
      checks++;
      if (obs_piece !== 4'h7 || obs_valid !== 1'b1) begin
         errors++;
         $display("FAIL midreset first piece: got v%0d p%h expected v1 p7", obs_valid, obs_piece);
      end
      tick();
      rst_n = 1'b0; drv_pready = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset valid after reset: got %0d expected 0", obs_valid);
      end
      tick();
      checks++;
      if (obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset discarded piece: valid %0d piece %h expected valid 0", obs_valid, obs_piece);
      end
      drv_word = 16'h0001; drv_wvalid = 1'b1; drv_pready = 1'b1;
      push_word(16'h0001, 2, 1'b1);
      tick();
      drv_wvalid = 1'b0;
      consume("after reset", 6);
   endtask

   task automatic test_random();
      int sent = 0;
      int n = 0;
      logic acc, xfer;
      logic [6:0] e;
      sel = 0; drv_wvalid = 1'b0;
      while ((sent < 10 || drv_wvalid || exp_q.size() > 0) && n < 400) begin
         drv_pready = ($urandom_range(0, 3) != 0);
         if (!drv_wvalid && sent < 10) begin
            drv_word = 16'($urandom_range(0, 255));
            drv_wvalid = 1'b1;
            push_word(drv_word, 2, 1'b1);
            sent++;
         end
         #1;
         acc  = drv_wvalid & obs_wready;
         xfer = obs_valid & drv_pready;
         if (xfer) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL random unexpected piece: got %h expected none", obs_piece);
            end else begin
               e = exp_q.pop_front();
               if ({obs_piece, obs_idx, obs_last} !== e) begin
                  errors++;
                  $display("FAIL random piece: got %h/%0d/%0d expected %h/%0d/%0d",
                           obs_piece, obs_idx, obs_last, e[6:3], e[2:1], e[0]);
               end
            end
         end
         tick();
         if (acc) drv_wvalid = 1'b0;
         n++;
      end
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL random timeout: %0d pieces outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      drv_wvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_lsb_first();
      test_wide_word();
      test_reset_mid_word();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_unpacker.md
Name: nibble_unpacker

Overview:
- Splits each WORD_W-bit word into NUM_PIECES = WORD_W/PIECE_W pieces and emits them one per handshake, most-significant piece first by default.
- Undoes the team's {upper, lower} concatenation packing: word 8'h7C produces pieces 4'h7 then 4'hC.
- Sits between a word-wide producer and a narrow downstream lane.
- Uses valid/ready on both sides; sustains full throughput with no bubble between words.

Parameters:
- WORD_W, 8: input word width; must be an integer multiple of PIECE_W (elaboration-time check, fatal).
- PIECE_W, 4: output piece width; must be at least 1.
- MSB_FIRST, 1: 1 emits the most-significant piece first; 0 emits the least-significant piece first.

Ports:
- i_CLOCK  in  1  single clock; all logic on the rising edge.
- i_RESET_N  in  1  synchronous, active-low reset.
- i_WORD_VALID  in  1  upstream word valid.
- o_WORD_READY  out  1  block accepts i_WORD this cycle.
- i_WORD  in  WORD_W  word to unpack.
- o_PIECE_VALID  out  1  o_PIECE valid.
- i_PIECE_READY  in  1  downstream accepts the piece.
- o_PIECE  out  PIECE_W  current piece.
- o_PIECE_IDX  out  IDX_W  emission index, 0..NUM_PIECES-1; IDX_W = max(1, clog2(NUM_PIECES)).
- o_PIECE_LAST  out  1  current piece is the final piece of its word.
- o_BUSY  out  1  a word is held, i.e. not all of its pieces are consumed.

Behaviour:
- The clock and reset are fixed: one clock, i_CLOCK; reset is synchronous and active-low on i_RESET_N.
- Reset (i_RESET_N low at a rising edge):
  - o_PIECE_VALID=0, o_PIECE=0, o_PIECE_IDX=0, o_PIECE_LAST=0, o_BUSY=0.
  - The held word and the counter clear to 0.
  - o_WORD_READY is forced 0 while i_RESET_N is low.
- Handshake definitions: word accept = i_WORD_VALID & o_WORD_READY; piece transfer = o_PIECE_VALID & i_PIECE_READY.
- FSM states and transitions:
  - IDLE (nothing held): o_WORD_READY=1, o_PIECE_VALID=0.
  - IDLE -> EMIT on word accept.
  - EMIT: o_PIECE_VALID=1.
  - EMIT: piece transfer with idx < NUM_PIECES-1 advances idx by 1.
  - EMIT: piece transfer on the last piece returns to IDLE, unless a new word is accepted in the same cycle, in which case the FSM stays in EMIT with idx=0 and the new word loaded.
- Ready rule: o_WORD_READY = !o_BUSY | (piece transfer & o_PIECE_LAST).
  - This is the only combinational path, i_PIECE_READY -> o_WORD_READY.
  - No other combinational input-to-output path is allowed.
- Latency: a word accepted at edge N has its first piece valid from edge N (visible the cycle after acceptance).
- Throughput: one piece per cycle, so one word per NUM_PIECES cycles when i_PIECE_READY is held high.
- Piece selection, with k = o_PIECE_IDX:
  - MSB_FIRST=1: o_PIECE = word[WORD_W-1-k*PIECE_W -: PIECE_W].
  - MSB_FIRST=0: o_PIECE = word[k*PIECE_W +: PIECE_W].
- o_PIECE_LAST = o_PIECE_VALID & (idx == NUM_PIECES-1).
- NUM_PIECES=1: every piece is last and the block degenerates to a one-deep register slice.
- Backpressure: while o_PIECE_VALID & !i_PIECE_READY, o_PIECE, o_PIECE_IDX and o_PIECE_LAST are held stable.
- i_WORD is ignored whenever o_WORD_READY=0; there is no overwrite of the held word.
- Index counter: saturates at NUM_PIECES-1 and never wraps while a piece is pending; it returns to 0 only on the last-piece transfer.
- Reset mid-word: the remaining pieces are discarded; o_PIECE_VALID=0 on the cycle after the reset edge.
- Outputs are fully registered, except o_WORD_READY as noted above.

Decomposition:
- Shared package nibble_pkg:
  - function idx_width(n) returning max(1, clog2(n)).
  - localparam default widths WORD_W_DEF=8, PIECE_W_DEF=4.
  - FSM state enum {IDLE, EMIT}.
- No sub-module; a single module holds the word register, counter and FSM.
- This block is the counterpart to a future nibble_packer, which reuses the same package.

Test Plan:
- Default parameters, ready held high, single word 8'h7C -> pieces 4'h7 (idx0, last0) then 4'hC (idx1, last1); o_BUSY 1 for exactly 2 cycles.
- Back-to-back words 8'h7C, 8'hE2 with valid and ready held high -> pieces 7, C, E, 2 on 4 consecutive cycles; o_WORD_READY high on the last-piece cycle; no bubble.
- Backpressure: i_PIECE_READY low for 3 cycles on piece 4'h7 -> o_PIECE holds 7 and idx holds 0; o_WORD_READY=0; a new word offered meanwhile is not taken.
- MSB_FIRST=0, word 8'h7C -> pieces 4'hC then 4'h7.
- WORD_W=16, word 16'hA5C3 -> pieces A, 5, C, 3 with idx 0..3; last asserted only on piece 3.
- Reset asserted for 1 cycle after piece 0 of 8'h7C transfers -> valid drops the next cycle; piece C never appears; the next word 8'h01 emits 0 then 1.
